// File: rtl/alpha_phase_sweep_pkg.sv
// Shared definitions for the alpha RAM phase-sweep sequencer.
package alpha_pkg;

   localparam int ALPHA_W = 8;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_NEG = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/alpha_phase_sweep_if.sv
// Controller and alpha-RAM port bundle for the phase sweep sequencer.
interface alpha_phase_sweep_if #(parameter int num_qubit = 3);

   logic                          start;
   logic                          op;
   logic [alpha_pkg::ALPHA_W-1:0] phase_inc;
   logic [num_qubit-1:0]          ctrl_mask;
   logic                          busy;
   logic                          done;
   logic [num_qubit-1:0]          read_address;
   logic [alpha_pkg::ALPHA_W-1:0] read_alpha;
   logic [num_qubit-1:0]          write_address;
   logic                          write_enable;
   logic [alpha_pkg::ALPHA_W-1:0] write_alpha;

   modport master (
      input  start, op, phase_inc, ctrl_mask, read_alpha,
      output busy, done, read_address, write_address, write_enable, write_alpha
   );

   modport slave (
      output start, op, phase_inc, ctrl_mask, read_alpha,
      input  busy, done, read_address, write_address, write_enable, write_alpha
   );

endinterface

// File: rtl/alpha_update_alu.sv
// Combinational per-entry phase update: wrapping add or two's-complement negate.
module alpha_update_alu
   import alpha_pkg::*;
(
   input  logic [ALPHA_W-1:0] alpha,
   input  logic               op,
   input  logic [ALPHA_W-1:0] phase_inc,
   input  logic               mask_hit,
   output logic [ALPHA_W-1:0] new_alpha,
   output logic               we
);

   function automatic logic [ALPHA_W-1:0] neg_wrap(input logic [ALPHA_W-1:0] a);
      // 0x00 and 0x80 are their own negation; no saturation wanted
      return ~a + ALPHA_W'(1);
   endfunction

   function automatic logic [ALPHA_W-1:0] add_wrap(input logic [ALPHA_W-1:0] a,
                                                   input logic [ALPHA_W-1:0] b);
      return a + b;
   endfunction

   always_comb begin
      new_alpha = add_wrap(alpha, phase_inc);
      if (op == OP_NEG) new_alpha = neg_wrap(alpha);
      we = mask_hit;
   end

endmodule

// File: rtl/alpha_phase_sweep.sv
// Read-modify-write sweep over the alpha RAM: one entry per cycle, 2-stage pipeline.
module alpha_phase_sweep
   import alpha_pkg::*;
#(
   parameter int num_qubit = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   alpha_phase_sweep_if.master  bus
);

   state_t               state;
   logic                 op_q;
   logic [ALPHA_W-1:0]   inc_q;
   logic [num_qubit-1:0] mask_q;
   logic [num_qubit-1:0] rd_addr;
   logic                 drain_cnt;
   logic                 busy_q;
   logic                 done_q;

   logic [num_qubit-1:0] addr_p1;
   logic                 vld_p1;

   logic [num_qubit-1:0] wr_addr_p2;
   logic [ALPHA_W-1:0]   wr_alpha_p2;
   logic                 wr_en_p2;

   logic [ALPHA_W-1:0]   alu_alpha;
   logic                 alu_we;
   logic                 mask_hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         op_q      <= OP_ADD;
         inc_q     <= '0;
         mask_q    <= '0;
         rd_addr   <= '0;
         drain_cnt <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state)
            // DONE accepts a new start exactly like IDLE
            S_IDLE, S_DONE: begin
               done_q <= 1'b0;
               state  <= S_IDLE;
               if (bus.start) begin
                  op_q    <= bus.op;
                  inc_q   <= bus.phase_inc;
                  mask_q  <= bus.ctrl_mask;
                  rd_addr <= '0;
                  busy_q  <= 1'b1;
                  state   <= S_SWEEP;
               end
            end
            S_SWEEP: begin
               if (rd_addr == '1) begin
                  rd_addr   <= '0;
                  drain_cnt <= 1'b0;
                  state     <= S_DRAIN;
               end else begin
                  rd_addr <= rd_addr + num_qubit'(1);
               end
            end
            S_DRAIN: begin
               drain_cnt <= 1'b1;
               if (drain_cnt) begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // stage 1: issued address and its valid bit, aligned with read_alpha
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         addr_p1 <= '0;
      end else begin
         vld_p1  <= (state == S_SWEEP);
         addr_p1 <= rd_addr;
      end
   end

   assign mask_hit = ((addr_p1 & mask_q) == mask_q);

   alpha_update_alu u_alu (
      .alpha     (bus.read_alpha),
      .op        (op_q),
      .phase_inc (inc_q),
      .mask_hit  (mask_hit),
      .new_alpha (alu_alpha),
      .we        (alu_we)
   );

   // stage 2: registered write port
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en_p2    <= 1'b0;
         wr_addr_p2  <= '0;
         wr_alpha_p2 <= '0;
      end else begin
         wr_en_p2 <= vld_p1 & alu_we;
         if (vld_p1) begin
            wr_addr_p2  <= addr_p1;
            wr_alpha_p2 <= alu_alpha;
         end
      end
   end

   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.read_address  = rd_addr;
   assign bus.write_address = wr_addr_p2;
   assign bus.write_enable  = wr_en_p2;
   assign bus.write_alpha   = wr_alpha_p2;

endmodule

// File: doc/alpha_phase_sweep.md
# alpha_phase_sweep

Read-modify-write sequencer that sweeps every entry of the alpha RAM (one 8-bit alpha per basis-state address) and applies a controlled phase update, writing results back. Sits directly upstream of `ram_alpha_control`: it drives that block's read address and write port and consumes its read data. The gate-level controller triggers one sweep per phase-type gate.

## Interface
Parameters:
- `num_qubit`, 3, address width; sweep covers M = 2^num_qubit entries

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  request a sweep; sampled only while `busy`=0
- `op`  in  1  0 = add `phase_inc`, 1 = negate alpha (two's complement); latched at start
- `phase_inc`  in  8  phase increment, unsigned mod 256; latched at start
- `ctrl_mask`  in  num_qubit  control mask; an address is updated iff (addr & mask) == mask; latched at start
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle pulse after the final write
- `read_address`  out  num_qubit  to RAM read port
- `read_alpha`  in  8  from RAM, valid one cycle after `read_address`
- `write_address`  out  num_qubit  to RAM write port
- `write_enable`  out  1  RAM write strobe
- `write_alpha`  out  8  updated alpha

## Operation
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE: `start`=1 latches `op`, `phase_inc`, `ctrl_mask`. Go to SWEEP with read counter = 0.
- SWEEP: drive `read_address` = counter and increment each cycle. After address M-1 is issued, go to DRAIN.
- DRAIN: lasts 2 cycles so the last two reads complete their writes. Then go to DONE.
- DONE: `done`=1 for one cycle. Return to IDLE. `start` sampled in DONE is accepted exactly as in IDLE.
- Pipeline:
  - Stage 1 registers the issued address and a valid bit.
  - Stage 2 computes from `read_alpha` and registers the write outputs.
- Update rule:
  - op=0: new = (alpha + phase_inc) mod 256, wrapping with no saturation.
  - op=1: new = (~alpha + 1) mod 256, so 0x00 maps to 0x00 and 0x80 maps to 0x80.
- Addresses failing the mask test are not written: `write_enable`=0 in their slot.
- `ctrl_mask`=0 selects every address.
- `start` while `busy`=1 is ignored and is not queued.
- Input changes after the start cycle have no effect on the current sweep.
- Addresses are distinct within a sweep, so there is no read-after-write hazard inside one sweep.
- A back-to-back sweep starts only after DONE, so all writes of the prior sweep have landed before its first read.

## Timing
- Reset values: `busy`=0, `done`=0, `write_enable`=0, `write_address`=0, `write_alpha`=0, `read_address`=0. FSM goes to IDLE and the pipeline valid bits clear.
- `rst` asserted mid-sweep: outputs take their reset values at the next edge and no further writes occur. A partial sweep is left in RAM; this is permitted.
- Cycle numbering: `start` is sampled at edge E0, and c1 is the cycle after E0.
  - `busy`=1 from c1 through c(M+2).
  - `read_address`=k in c(k+1), for k = 0..M-1.
  - Write for address k appears in c(k+3): `write_enable`, `write_address`=k, `write_alpha`.
  - `done`=1 in c(M+3) with `busy`=0.
- Throughput: one entry per cycle. Total sweep latency from start edge to `done` is M+3 cycles.
- `read_address` holds 0 outside SWEEP.

## Structure
- Shared package `alpha_pkg` holds:
  - the alpha width constant (8)
  - the FSM state enum
  - the op encoding constants (OP_ADD=0, OP_NEG=1)
- Natural sub-module `alpha_update_alu`: combinational. Inputs are alpha, op, phase_inc and mask-hit; outputs are new alpha and write-enable. It is instantiated in stage 2.
- The sweep counter and FSM stay in the top module.
- The top module instantiates nothing else. The RAM is external and connected at the integration level alongside `ram_alpha_control`.

## Test plan
Conditions for all scenarios: num_qubit=3 (M=8), with a behavioural RAM model that has 1-cycle read latency.

- RAM[k]=k; start with op=0, phase_inc=0x05, mask=0 -> RAM[k]=k+5 for all k. Writes occur in c3..c10, `done` in c11, `busy` high for exactly 10 cycles.
- RAM[k]=0xFE; op=0, phase_inc=0x03, mask=3'b101 -> addresses 5 and 7 become 0x01 (wrap), all others stay 0xFE, and `write_enable` is never high for the others.
- RAM = {0x00,0x80,0x01,0x7F,...}; op=1, mask=0 -> {0x00,0x80,0xFF,0x81,...}.
- `start` pulsed again at c4 and c8 of a sweep -> both ignored. A single `done`, exactly 8 write slots, no second sweep.
- Second `start` asserted in the `done` cycle -> second sweep begins the next cycle with `read_address`=0. Final RAM reflects both updates applied in order (two adds of 0x05 give +0x0A).
- `rst` asserted at c5 -> next cycle `busy`=0, `write_enable`=0, no `done`. A subsequent start performs a clean full sweep.
